// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, branch squash, data-memory
// freeze with a watchdog that turns a hung access into a sticky fault and a full flush.
module pipeline_hazard_controller #(
  parameter int unsigned RegAddWidth = 5,
  parameter int unsigned DmemTimeout = 16,
  parameter int unsigned CountWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RegAddWidth-1:0] rs1_id_i,
  input  logic [RegAddWidth-1:0] rs2_id_i,
  input  logic                   rs1_used_id_i,
  input  logic                   rs2_used_id_i,
  input  logic [RegAddWidth-1:0] rd_ex_i,
  input  logic                   mem_read_ex_i,
  input  logic                   branch_taken_ex_i,
  input  logic                   dmem_req_mem_i,
  input  logic                   dmem_ready_i,
  output logic                   stall_if_o,
  output logic                   stall_id_o,
  output logic                   stall_ex_o,
  output logic                   stall_mem_o,
  output logic                   bubble_ex_o,
  output logic                   bubble_wb_o,
  output logic                   flush_if_id_o,
  output logic                   flush_id_ex_o,
  output logic                   flush_ex_mem_o,
  output logic                   mem_fault_o,
  output logic [1:0]             state_o,
  output logic [CountWidth-1:0]  stall_cycles_o
);

  localparam int unsigned WcntWidth = $clog2(DmemTimeout) + 1;
  localparam logic [WcntWidth-1:0] WcntLast = WcntWidth'(DmemTimeout - 1);

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StDwait = 2'b01,
    StFault = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [WcntWidth-1:0]   wcnt_q, wcnt_d;
  logic                   mem_fault_q, mem_fault_d;
  logic [CountWidth-1:0]  stall_cycles_q, stall_cycles_d;

  logic dstall;
  logic rs1_hit;
  logic rs2_hit;
  logic lu;

  assign dstall  = dmem_req_mem_i & ~dmem_ready_i;
  assign rs1_hit = rs1_used_id_i & (rs1_id_i == rd_ex_i);
  assign rs2_hit = rs2_used_id_i & (rs2_id_i == rd_ex_i);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu      = mem_read_ex_i & (rd_ex_i != '0) & (rs1_hit | rs2_hit);

  always_comb begin
    stall_if_o     = 1'b0;
    stall_id_o     = 1'b0;
    stall_ex_o     = 1'b0;
    stall_mem_o    = 1'b0;
    bubble_ex_o    = 1'b0;
    bubble_wb_o    = 1'b0;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    flush_ex_mem_o = 1'b0;
    if (!rst_i) begin
      if (state_q == StFault) begin
        flush_if_id_o  = 1'b1;
        flush_id_ex_o  = 1'b1;
        flush_ex_mem_o = 1'b1;
        bubble_wb_o    = 1'b1;
      end else if (dstall) begin
        // Freeze everything; a pending branch stays in EX and flushes once the pipe moves.
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        stall_mem_o = 1'b1;
        bubble_wb_o = 1'b1;
      end else if (branch_taken_ex_i) begin
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (lu) begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        bubble_ex_o = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      StRun: begin
        if (dstall) begin
          state_d = StDwait;
          wcnt_d  = WcntWidth'(1);
        end else begin
          wcnt_d  = '0;
        end
      end
      StDwait: begin
        if (!dstall) begin
          state_d = StRun;
          wcnt_d  = '0;
        end else if (wcnt_q == WcntLast) begin
          state_d = StFault;
          wcnt_d  = '0;
        end else begin
          wcnt_d  = wcnt_q + WcntWidth'(1);
        end
      end
      StFault: begin
        state_d = StRun;
        wcnt_d  = '0;
      end
      default: begin
        state_d = StRun;
        wcnt_d  = '0;
      end
    endcase
  end

  assign mem_fault_d    = mem_fault_q | (state_q == StFault);
  assign stall_cycles_d = (stall_if_o && (stall_cycles_q != '1)) ?
                          stall_cycles_q + CountWidth'(1) : stall_cycles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StRun;
      wcnt_q         <= '0;
      mem_fault_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      mem_fault_q    <= mem_fault_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_fault_o    = mem_fault_q;
  assign state_o        = state_q;
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: stimulus pushes expected responses from a cycle-counting model, a negedge
// monitor pops and compares them against the controller outputs.
module tb_pipeline_hazard_controller;

  localparam int unsigned T      = 4;
  localparam int unsigned CW     = 4;
  localparam int          MaxCnt = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, u1, u2, ld, br, req, rdy;
  logic [4:0]    rs1, rs2, rd;
  logic          stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb;
  logic          flush_if_id, flush_id_ex, flush_ex_mem, mem_fault;
  logic [1:0]    state;
  logic [CW-1:0] stall_cycles;

  pipeline_hazard_controller #(
    .RegAddWidth(5),
    .DmemTimeout(T),
    .CountWidth (CW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .rs1_id_i         (rs1),
    .rs2_id_i         (rs2),
    .rs1_used_id_i    (u1),
    .rs2_used_id_i    (u2),
    .rd_ex_i          (rd),
    .mem_read_ex_i    (ld),
    .branch_taken_ex_i(br),
    .dmem_req_mem_i   (req),
    .dmem_ready_i     (rdy),
    .stall_if_o       (stall_if),
    .stall_id_o       (stall_id),
    .stall_ex_o       (stall_ex),
    .stall_mem_o      (stall_mem),
    .bubble_ex_o      (bubble_ex),
    .bubble_wb_o      (bubble_wb),
    .flush_if_id_o    (flush_if_id),
    .flush_id_ex_o    (flush_id_ex),
    .flush_ex_mem_o   (flush_ex_mem),
    .mem_fault_o      (mem_fault),
    .state_o          (state),
    .stall_cycles_o   (stall_cycles)
  );

  // ctrl = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, flush x3}
  typedef struct packed {
    logic [8:0]    ctrl;
    logic [1:0]    st;
    logic          mf;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: length of the current run of memory-stall cycles, fault pending.
  int streak = 0;
  bit fault_now = 0;
  bit m_fault = 0;
  int m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, req_v);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ctrl", 32'({stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb,
                         flush_if_id, flush_id_ex, flush_ex_mem}), 32'(e.ctrl));
      check("state", 32'(state), 32'(e.st));
      check("mem_fault", 32'(mem_fault), 32'(e.mf));
      check("stall_cycles", 32'(stall_cycles), 32'(e.sc));
    end
  end

  task automatic clr();
    rst = 0; u1 = 0; u2 = 0; ld = 0; br = 0; req = 0; rdy = 0;
    rs1 = 0; rs2 = 0; rd = 0;
  endtask

  // Apply the current inputs for one cycle; expected outputs follow from the model.
  task automatic step();
    exp_t e;
    bit   ds, hz;
    ds = req && !rdy;
    hz = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e.ctrl = '0;
    e.st   = fault_now ? 2'b10 : (streak > 0 ? 2'b01 : 2'b00);
    e.mf   = m_fault;
    e.sc   = CW'(m_cnt);
    if (!rst) begin
      if (fault_now)  e.ctrl = 9'b000001111;
      else if (ds)    e.ctrl = 9'b111101000;
      else if (br)    e.ctrl = 9'b000000110;
      else if (hz)    e.ctrl = 9'b110010000;
    end
    exp_q.push_back(e);
    if (rst) begin
      streak = 0; fault_now = 0; m_fault = 0; m_cnt = 0;
    end else begin
      if (e.ctrl[8] && m_cnt < MaxCnt) m_cnt++;
      if (fault_now) begin
        fault_now = 0; m_fault = 1; streak = 0;
      end else if (ds) begin
        if (streak + 1 == T) begin
          fault_now = 1; streak = 0;
        end else begin
          streak++;
        end
      end else begin
        streak = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_lu();
    clr(); rd = 5; ld = 1; rs1 = 5; u1 = 1;
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk);
    #1;
    clr(); rst = 1; step();
    idle(1);

    // Load-use and its non-hazard variants
    set_lu(); step();
    idle(1);
    set_lu(); rd = 0; rs1 = 0; step();
    set_lu(); u1 = 0; step();
    clr(); rd = 7; ld = 1; rs2 = 7; u2 = 1; step();
    set_lu(); br = 1; step();
    idle(1);

    // Three-cycle memory stall, then ready
    clr(); req = 1;
    for (int i = 0; i < 3; i++) step();
    rdy = 1; step();
    idle(1);

    // Hung access: timeout, fault, then release
    clr(); req = 1;
    for (int i = 0; i < T + 3; i++) step();
    idle(2);

    // Ready in the last allowed stall cycle
    clr(); req = 1;
    for (int i = 0; i < T - 1; i++) step();
    rdy = 1; step();
    idle(1);

    // Branch held in a frozen EX during a 2-cycle stall
    clr(); req = 1; br = 1;
    for (int i = 0; i < 2; i++) step();
    rdy = 1; step();
    idle(1);

    // Counter saturation, then reset in the middle of a memory wait
    set_lu();
    for (int i = 0; i < 20; i++) step();
    clr(); req = 1;
    for (int i = 0; i < 2; i++) step();
    rst = 1; step();
    clr(); req = 1; step();
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      ld  = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 5) == 0);
      req = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    idle(1);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
